// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS pipeline front end.
//   fetch_state_t    : fetch FSM states (IDLE, FETCH, WAIT, HOLD)
//   OPCODE_HI/LO     : bit range of the opcode field in an instruction word
//   INSTR_W          : instruction word width
//   RESET_PC_DEFAULT : first fetch address after reset
// -----------------------------------------------------------------------------
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } fetch_state_t;

   localparam int unsigned OPCODE_HI = 31;
   localparam int unsigned OPCODE_LO = 26;
   localparam int unsigned INSTR_W   = 32;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/mips_fetch_stage_if.sv
// -----------------------------------------------------------------------------
// mips_fetch_stage_if
// Instruction-memory handshake (req/gnt/rvalid, one request outstanding).
//   req    : fetch request, master -> slave
//   addr   : fetch address, master -> slave (sampled by the memory on req&gnt)
//   gnt    : request accepted this cycle, slave -> master
//   rvalid : read data valid, slave -> master
//   rdata  : instruction word, slave -> master
// Modports: master (fetch stage), slave (instruction memory).
// -----------------------------------------------------------------------------
interface mips_fetch_stage_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) ();

   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );

endinterface : mips_fetch_stage_if

// File: rtl/mips_fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register.
//   clk, rst        : clock, asynchronous active-low reset
//   load            : capture instr_in / pc_plus4_in and mark valid
//   stall           : hold all fields
//   flush           : invalidate (wins over stall and load)
//   instr_in        : instruction word to capture
//   pc_plus4_in     : PC+4 of that instruction
//   valid/instr/pc_plus4 : register contents
// Priority: flush > stall > load > bubble. A bubble clears only valid; the
// data fields keep their last value.
// -----------------------------------------------------------------------------
module if_id_reg #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              stall,
   input  logic              flush,
   input  logic [DATA_W-1:0] instr_in,
   input  logic [ADDR_W-1:0] pc_plus4_in,
   output logic              valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] pc_plus4
);

   logic              valid_q,    valid_d;
   logic [DATA_W-1:0] instr_q,    instr_d;
   logic [ADDR_W-1:0] pc_plus4_q, pc_plus4_d;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      valid_d    = valid_q;
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (stall) begin
         valid_d = valid_q;
      end else if (load) begin
         valid_d    = 1'b1;
         instr_d    = instr_in;
         pc_plus4_d = pc_plus4_in;
      end else begin
         valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its pre-edge inputs regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q    <= 1'b0;
         instr_q    <= '0;
         pc_plus4_q <= '0;
      end else begin
         valid_q    <= valid_d;
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
      end
   end

   assign valid    = valid_q;
   assign instr    = instr_q;
   assign pc_plus4 = pc_plus4_q;

endmodule : if_id_reg

// File: rtl/mips_fetch_stage.sv
// -----------------------------------------------------------------------------
// mips_fetch_stage
// Instruction fetch stage: PC, fetch FSM, hold buffer and the IF/ID register.
//   clk, rst       : clock, asynchronous active-low reset
//   stall          : decode cannot accept; IF/ID holds
//   redirect       : one-cycle pulse, refetch from redirect_pc and flush IF/ID
//   redirect_pc    : redirect target (bits [1:0] ignored, forced to 00)
//   imem           : instruction-memory handshake (master side)
//   if_id_valid    : IF/ID holds a valid instruction
//   if_id_instr    : IF/ID instruction
//   if_id_pc_plus4 : PC+4 of the IF/ID instruction
//   opcode         : if_id_instr[31:26] for the control unit
//   pc             : current fetch PC (also driven on imem.addr)
// -----------------------------------------------------------------------------
module mips_fetch_stage
   import mips_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_pc,
   mips_fetch_stage_if.master  imem,
   output logic                if_id_valid,
   output logic [DATA_W-1:0]   if_id_instr,
   output logic [ADDR_W-1:0]   if_id_pc_plus4,
   output logic [5:0]          opcode,
   output logic [ADDR_W-1:0]   pc
);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic              discard_q, discard_d;
   logic [DATA_W-1:0] hold_q, hold_d;

   logic              load;
   logic [DATA_W-1:0] load_instr;
   logic [ADDR_W-1:0] redirect_tgt;

   // Word-align the target by masking rather than slicing, so every input bit
   // is consumed.
   assign redirect_tgt = redirect_pc & ~ADDR_W'(3);

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inflight_pc_d = inflight_pc_q;
      discard_d     = discard_q;
      hold_d        = hold_q;
      load          = 1'b0;
      load_instr    = imem.rdata;

      unique case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (imem.gnt) begin
               inflight_pc_d = pc_q;
               pc_d          = pc_q + ADDR_W'(4);
               state_d       = WAIT;
               // A grant in the redirect cycle fetched the wrong path.
               if (redirect) discard_d = 1'b1;
            end
         end
         WAIT: begin
            if (imem.rvalid) begin
               if (discard_q || redirect) begin
                  discard_d = 1'b0;
                  state_d   = FETCH;
               end else if (!stall) begin
                  load    = 1'b1;
                  state_d = FETCH;
               end else begin
                  hold_d  = imem.rdata;
                  state_d = HOLD;
               end
            end else if (redirect) begin
               // The response still in flight belongs to the old path.
               discard_d = 1'b1;
            end
         end
         HOLD: begin
            if (redirect) begin
               state_d = FETCH;
            end else if (!stall) begin
               load       = 1'b1;
               load_instr = hold_q;
               state_d    = FETCH;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (redirect) pc_d = redirect_tgt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         inflight_pc_q <= '0;
         discard_q     <= 1'b0;
         hold_q        <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         inflight_pc_q <= inflight_pc_d;
         discard_q     <= discard_d;
         hold_q        <= hold_d;
      end
   end

   // inflight_pc is still valid in HOLD: no new request is issued there.
   if_id_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_if_id (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .stall       (stall),
      .flush       (redirect),
      .instr_in    (load_instr),
      .pc_plus4_in (inflight_pc_q + ADDR_W'(4)),
      .valid       (if_id_valid),
      .instr       (if_id_instr),
      .pc_plus4    (if_id_pc_plus4)
   );

   assign imem.req  = (state_q == FETCH);
   assign imem.addr = pc_q;
   assign pc        = pc_q;
   assign opcode    = if_id_instr[OPCODE_HI:OPCODE_LO];

endmodule : mips_fetch_stage

// File: tb/tb_mips_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_mips_fetch_stage
// Self-checking bench for mips_fetch_stage. The bench plays the instruction
// memory; every word it returns on the correct path is pushed to a scoreboard
// and popped when IF/ID loads a new instruction.
// -----------------------------------------------------------------------------
module tb_mips_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic [5:0]  opcode;
   logic [31:0] pc;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
   } sb_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          gnt_wait;
      int          stall_cycles;
      logic [5:0]  opc;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[4];

   logic pre_valid;
   logic pre_stall;

   mips_fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem_bus ();

   mips_fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem           (imem_bus.master),
      .if_id_valid    (if_id_valid),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .opcode         (opcode),
      .pc             (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // IF/ID loaded at the last edge unless it was merely holding under stall.
   always @(posedge clk) begin
      pre_valid <= if_id_valid;
      pre_stall <= stall;
   end

   always @(negedge clk) begin
      if (rst && if_id_valid && !(pre_valid && pre_stall)) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_load: got instr 0x%08h, expected no load", if_id_instr);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            check("sb_instr", if_id_instr, e.instr);
            check("sb_pc_plus4", if_id_pc_plus4, e.pc_plus4);
            check("sb_opcode", {26'b0, opcode}, {26'b0, e.instr[31:26]});
         end
      end
   end

   // Waits at negedges for a request; a timeout counts as a failure.
   task automatic wait_req();
      int n = 0;
      while (imem_bus.req !== 1'b1 && n < 16) begin
         @(negedge clk);
         n++;
      end
      if (imem_bus.req !== 1'b1) check("req_timeout", {31'b0, imem_bus.req}, 32'd1);
   endtask

   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                           input int gnt_wait, input int stall_cycles);
      logic [31:0] held;
      wait_req();
      check("req_addr", imem_bus.addr, addr);
      for (int i = 0; i < gnt_wait; i++) begin
         @(negedge clk);
         check("req_held", {31'b0, imem_bus.req}, 32'd1);
         check("addr_held", imem_bus.addr, addr);
      end
      imem_bus.gnt = 1'b1;
      @(negedge clk);
      imem_bus.gnt = 1'b0;
      check("req_low_wait", {31'b0, imem_bus.req}, 32'd0);
      check("pc_advanced", pc, addr + 32'd4);
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = data;
      stall = (stall_cycles > 0);
      sb_q.push_back('{instr: data, pc_plus4: addr + 32'd4});
      held = if_id_instr;
      @(negedge clk);
      imem_bus.rvalid = 1'b0;
      imem_bus.rdata  = $urandom;
      for (int i = 0; i < stall_cycles; i++) begin
         check("hold_req_low", {31'b0, imem_bus.req}, 32'd0);
         check("hold_valid", {31'b0, if_id_valid}, 32'd0);
         check("hold_instr", if_id_instr, held);
         if (i == stall_cycles - 1) stall = 1'b0;
         @(negedge clk);
      end
      check("loaded_valid", {31'b0, if_id_valid}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{addr: 32'h0000_0000, data: 32'h8C01_0004, gnt_wait: 0, stall_cycles: 0, opc: 6'h23};
      vecs[1] = '{addr: 32'h0000_0004, data: 32'h0022_1820, gnt_wait: 0, stall_cycles: 3, opc: 6'h00};
      vecs[2] = '{addr: 32'h0000_0008, data: 32'h2002_0005, gnt_wait: 2, stall_cycles: 0, opc: 6'h08};
      vecs[3] = '{addr: 32'h0000_000C, data: 32'hAC03_0008, gnt_wait: 1, stall_cycles: 1, opc: 6'h2B};

      rst             = 1'b0;
      stall           = 1'b0;
      redirect        = 1'b0;
      redirect_pc     = '0;
      imem_bus.gnt    = 1'b0;
      imem_bus.rvalid = 1'b0;
      imem_bus.rdata  = '0;

      // Reset state and first request one cycle after release.
      repeat (3) @(negedge clk);
      check("rst_req", {31'b0, imem_bus.req}, 32'd0);
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'b0, if_id_valid}, 32'd0);
      check("rst_instr", if_id_instr, 32'h0);
      rst = 1'b1;
      #1 check("idle_req", {31'b0, imem_bus.req}, 32'd0);
      @(negedge clk);
      check("first_req", {31'b0, imem_bus.req}, 32'd1);

      // Table-driven fetches: basic, stalled, delayed grants.
      foreach (vecs[i]) begin
         do_fetch(vecs[i].addr, vecs[i].data, vecs[i].gnt_wait, vecs[i].stall_cycles);
         check("vec_opcode", {26'b0, opcode}, {26'b0, vecs[i].opc});
         check("vec_pc_plus4", if_id_pc_plus4, vecs[i].addr + 32'd4);
      end

      // Redirect during WAIT; late response is dropped.
      wait_req();
      check("t3_addr", imem_bus.addr, 32'h10);
      imem_bus.gnt = 1'b1;
      @(negedge clk);
      imem_bus.gnt = 1'b0;
      redirect     = 1'b1;
      redirect_pc  = 32'h0000_0041;
      @(negedge clk);
      redirect = 1'b0;
      check("t3_req_wait", {31'b0, imem_bus.req}, 32'd0);
      check("t3_pc", pc, 32'h40);
      check("t3_valid", {31'b0, if_id_valid}, 32'd0);
      @(negedge clk);
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      imem_bus.rvalid = 1'b0;
      check("t3_req", {31'b0, imem_bus.req}, 32'd1);
      check("t3_next_addr", imem_bus.addr, 32'h40);
      check("t3_valid_after", {31'b0, if_id_valid}, 32'd0);

      // Redirect in the grant cycle: granted fetch is wrong-path.
      do_fetch(32'h40, 32'h8C22_0000, 0, 0);
      wait_req();
      check("t4_addr", imem_bus.addr, 32'h44);
      imem_bus.gnt = 1'b1;
      redirect     = 1'b1;
      redirect_pc  = 32'h0000_0080;
      @(negedge clk);
      imem_bus.gnt = 1'b0;
      redirect     = 1'b0;
      check("t4_req_wait", {31'b0, imem_bus.req}, 32'd0);
      check("t4_pc", pc, 32'h80);
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = 32'h1111_1111;
      @(negedge clk);
      imem_bus.rvalid = 1'b0;
      check("t4_req", {31'b0, imem_bus.req}, 32'd1);
      check("t4_next_addr", imem_bus.addr, 32'h80);
      check("t4_valid", {31'b0, if_id_valid}, 32'd0);
      do_fetch(32'h80, 32'h0043_2025, 0, 0);

      // Redirect in FETCH without grant; target low bits forced to 00.
      wait_req();
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      @(negedge clk);
      redirect = 1'b0;
      check("rf_req", {31'b0, imem_bus.req}, 32'd1);
      check("rf_addr", imem_bus.addr, 32'hFFFF_FFFC);

      // PC wrap.
      do_fetch(32'hFFFF_FFFC, 32'h0800_0010, 0, 0);
      check("wrap_pc_plus4", if_id_pc_plus4, 32'h0);

      // Reset mid-WAIT with rvalid during and just after reset.
      do_fetch(32'h0, 32'h3C01_1234, 0, 0);
      wait_req();
      imem_bus.gnt = 1'b1;
      @(negedge clk);
      imem_bus.gnt = 1'b0;
      rst = 1'b0;
      #1;
      check("mr_req", {31'b0, imem_bus.req}, 32'd0);
      check("mr_addr", imem_bus.addr, 32'h0);
      check("mr_valid", {31'b0, if_id_valid}, 32'd0);
      check("mr_instr", if_id_instr, 32'h0);
      check("mr_pc_plus4", if_id_pc_plus4, 32'h0);
      check("mr_opcode", {26'b0, opcode}, 32'h0);
      imem_bus.rvalid = 1'b1;
      imem_bus.rdata  = 32'hFFFF_FFFF;
      @(negedge clk);
      imem_bus.rvalid = 1'b0;
      @(negedge clk);
      rst             = 1'b1;
      imem_bus.rvalid = 1'b1;
      @(negedge clk);
      imem_bus.rvalid = 1'b0;
      check("mr_req_after", {31'b0, imem_bus.req}, 32'd1);
      check("mr_addr_after", imem_bus.addr, 32'h0);
      check("mr_valid_after", {31'b0, if_id_valid}, 32'd0);
      do_fetch(32'h0, 32'h2401_0007, 0, 0);

      @(negedge clk);
      check("sb_empty", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_mips_fetch_stage
